lut_digit_mac: RTL and testbench
================================

Name: lut_digit_mac

Overview:
- Parametrised multi-cycle multiply-accumulate unit for systolic-array processing elements.
- Splits operands A and B into DIGIT_BITS-wide digits and looks up each digit product in an internal product table.
- Shifts each digit product by (i+j)*DIGIT_BITS and accumulates it, one digit pair per cycle.
- Generalises single-digit table lookup to arbitrary width, adds valid/ready handshakes and optional accumulation onto the previous result.

Parameters:
- DATA_WIDTH, 8, operand width in bits; must be an integer multiple of DIGIT_BITS.
- DIGIT_BITS, 4, digit width; table has 2^(2*DIGIT_BITS) entries of 2*DIGIT_BITS bits.
- ACC_WIDTH, 24, accumulator/result width; must be >= 2*DATA_WIDTH.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, synchronous active-high reset.
- in_valid, input, 1, operand presented.
- in_ready, output, 1, block can accept operands.
- a, input, DATA_WIDTH, unsigned multiplicand.
- b, input, DATA_WIDTH, unsigned multiplier.
- acc_clr, input, 1, sampled with operands: 1 = start from 0, 0 = add onto held result.
- out_valid, output, 1, result available.
- out_ready, input, 1, consumer takes result.
- result, output, ACC_WIDTH, accumulator value.

Behaviour:
- Definitions: N = DATA_WIDTH/DIGIT_BITS; digit k of x = x[k*DIGIT_BITS +: DIGIT_BITS].
- Product table:
  - Built at elaboration by a constant function (no file load).
  - Entry {p,q} = p*q.
  - Read combinationally.
- Reset (rst=1 at a rising edge):
  - state=IDLE, acc=0, i=j=0, out_valid=0, captured operands=0.
  - in_ready=0 while rst is high.
  - Reset mid-COMPUTE or in DONE aborts the operation; the partial result is discarded.
- State IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid && in_ready: capture a and b; if acc_clr=1 clear acc; set i=j=0; go to COMPUTE.
- State COMPUTE:
  - in_ready=0.
  - Each edge: acc <= acc + (table[a_i, b_j] << ((i+j)*DIGIT_BITS)), truncated to ACC_WIDTH (modulo 2^ACC_WIDTH wrap; no saturation, no flag).
  - Index order: j increments; at j=N-1, j wraps to 0 and i increments.
  - The edge that processes (N-1,N-1) moves to DONE.
  - Zero digits still consume a cycle; latency is fixed.
- State DONE:
  - out_valid=1; result stable.
  - On out_ready=1: go to IDLE. acc is retained for a later acc_clr=0 operation.
  - No accept in the same cycle as result hand-off (in_ready=0 in DONE).
- Latency and throughput:
  - out_valid rises exactly N^2 edges after the accepting edge.
  - Minimum initiation interval is N^2+2 cycles.
- result:
  - Always drives acc.
  - Meaningful only while out_valid=1; in other states it may show partial sums.
- Input and handshake rules:
  - a, b and acc_clr are ignored except at the accepting edge.
  - out_ready is ignored outside DONE.
  - in_valid may be held indefinitely without side effects.

Test Plan:
- Defaults, acc_clr=1, a=200, b=150 -> out_valid rises 4 edges after accept; result=30000.
- Accumulate chain: a=3, b=5, acc_clr=1 -> 15; then a=7, b=11, acc_clr=0 -> 92; then a=0, b=99, acc_clr=0 -> 92.
- Extremes: 255*255, acc_clr=1 -> 65025; 0*255 -> 0 with the same 4-cycle latency.
- Overflow, ACC_WIDTH=16: 255*255 acc_clr=1, then 255*255 acc_clr=0 -> 64514 (130050 mod 65536).
- Back-pressure and reset:
  - Hold out_ready=0 for 10 cycles: result stays 30000, in_ready stays 0.
  - Assert rst at the 2nd COMPUTE edge: next cycle in_ready=0, out_valid=0, acc=0; after release in_ready=1.
- DATA_WIDTH=12, DIGIT_BITS=4: 4095*4095 -> 16769025 after 9 edges.

Source files
------------

// File: rtl/lut_digit_mac.sv
// lut_digit_mac
//   Multi-cycle unsigned multiply-accumulate for systolic-array PEs.
//   Each operand is split into DIGIT_BITS-wide digits. Every digit-pair
//   product is taken from a constant product table. It is shifted into place
//   and added to the accumulator, one digit pair per clock.
//   With N = DATA_WIDTH/DIGIT_BITS, the result is valid N*N edges after accept.
//
// Ports
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   in_valid  operands presented
//   in_ready  block can accept operands (IDLE only, low while rst is high)
//   a, b      unsigned operands, DATA_WIDTH bits
//   acc_clr   sampled with operands: 1 = start from zero, 0 = add onto held acc
//   out_valid result available (DONE)
//   out_ready consumer takes the result
//   result    accumulator value, ACC_WIDTH bits (modulo 2^ACC_WIDTH)
module lut_digit_mac #(
  parameter int DATA_WIDTH = 8,
  parameter int DIGIT_BITS = 4,
  parameter int ACC_WIDTH  = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  acc_clr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_WIDTH-1:0]  result
);

  localparam int N       = DATA_WIDTH / DIGIT_BITS;
  localparam int PB      = 2 * DIGIT_BITS;
  localparam int ENTRIES = 1 << PB;
  localparam int IDX_W   = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  // Catch illegal parameter combinations at elaboration time.
  if (DATA_WIDTH % DIGIT_BITS != 0) begin : g_bad_digit
    $error("lut_digit_mac: DATA_WIDTH must be a multiple of DIGIT_BITS");
  end
  if (ACC_WIDTH < 2 * DATA_WIDTH) begin : g_bad_acc
    $error("lut_digit_mac: ACC_WIDTH must be >= 2*DATA_WIDTH");
  end

  // Table entry {p,q} = p*q. The high half of the index is the a-digit and
  // the low half is the b-digit.
  function automatic logic [PB-1:0] table_entry(input int idx);
    int p;
    int q;
    p = (idx >> DIGIT_BITS) & ((1 << DIGIT_BITS) - 1);
    q = idx & ((1 << DIGIT_BITS) - 1);
    return PB'(p * q);
  endfunction

  logic [PB-1:0] prod_table [ENTRIES];

  for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_table
    assign prod_table[gi] = table_entry(gi);
  end

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

  state_t                  state_reg;
  logic [DATA_WIDTH-1:0]   a_reg;
  logic [DATA_WIDTH-1:0]   b_reg;
  logic [ACC_WIDTH-1:0]    acc_reg;
  logic [IDX_W-1:0]        i_reg;
  logic [IDX_W-1:0]        j_reg;
  logic                    out_valid_reg;

  logic [DIGIT_BITS-1:0]   a_digit;
  logic [DIGIT_BITS-1:0]   b_digit;
  logic [PB-1:0]           prod;
  int                      shift;
  logic [ACC_WIDTH-1:0]    acc_next;

  // Current digit pair, its table product and its weighted contribution.
  // The sum wraps at ACC_WIDTH bits.
  always_comb begin
    a_digit  = a_reg[i_reg*DIGIT_BITS +: DIGIT_BITS];
    b_digit  = b_reg[j_reg*DIGIT_BITS +: DIGIT_BITS];
    prod     = prod_table[{a_digit, b_digit}];
    shift    = (int'(i_reg) + int'(j_reg)) * DIGIT_BITS;
    acc_next = acc_reg + (ACC_WIDTH'(prod) << shift);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      a_reg         <= '0;
      b_reg         <= '0;
      acc_reg       <= '0;
      i_reg         <= '0;
      j_reg         <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= a;
            b_reg     <= b;
            i_reg     <= '0;
            j_reg     <= '0;
            state_reg <= COMPUTE;
            if (acc_clr) begin
              acc_reg <= '0;
            end
          end
        end

        COMPUTE: begin
          acc_reg <= acc_next;
          if (j_reg == LAST_IDX) begin
            j_reg <= '0;
            if (i_reg == LAST_IDX) begin
              i_reg         <= '0;
              state_reg     <= DONE;
              out_valid_reg <= 1'b1;
            end else begin
              i_reg <= i_reg + 1'b1;
            end
          end else begin
            j_reg <= j_reg + 1'b1;
          end
        end

        DONE: begin
          // acc is kept so that a later acc_clr=0 operation builds on it.
          if (out_ready) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
          end
        end

        default: begin
          state_reg     <= IDLE;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  // Gating with rst keeps in_ready low before the first reset edge has landed.
  assign in_ready  = (state_reg == IDLE) && !rst;
  assign out_valid = out_valid_reg;
  assign result    = acc_reg;

endmodule

// File: tb/tb_lut_digit_mac.sv
// Testbench for lut_digit_mac. There are three instances:
//   dut     : defaults (8/4/24). Gets randomized and directed traffic, random
//             back-pressure, a hold test and a reset abort.
//   dut_ovf : ACC_WIDTH=16. Exercises accumulator wrap.
//   dut_w   : DATA_WIDTH=12. Uses a 9-edge latency.
// The expected results come from plain integer arithmetic, (acc + a*b) mod 2^W.
// They are queued at issue time and popped by monitors at each hand-off.
module tb_lut_digit_mac;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic hold;
  logic always_ready;

  // default instance
  logic        in_valid, in_ready, acc_clr, out_valid, out_ready;
  logic [7:0]  a, b;
  logic [23:0] result;

  // overflow instance
  logic        o_in_valid, o_in_ready, o_acc_clr, o_out_valid;
  logic [7:0]  o_a, o_b;
  logic [15:0] o_result;

  // wide instance
  logic        w_in_valid, w_in_ready, w_acc_clr, w_out_valid;
  logic [11:0] w_a, w_b;
  logic [23:0] w_result;

  lut_digit_mac #(.DATA_WIDTH(8), .DIGIT_BITS(4), .ACC_WIDTH(24)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .acc_clr(acc_clr), .out_valid(out_valid),
    .out_ready(out_ready), .result(result)
  );

  lut_digit_mac #(.DATA_WIDTH(8), .DIGIT_BITS(4), .ACC_WIDTH(16)) dut_ovf (
    .clk(clk), .rst(rst), .in_valid(o_in_valid), .in_ready(o_in_ready),
    .a(o_a), .b(o_b), .acc_clr(o_acc_clr), .out_valid(o_out_valid),
    .out_ready(always_ready), .result(o_result)
  );

  lut_digit_mac #(.DATA_WIDTH(12), .DIGIT_BITS(4), .ACC_WIDTH(24)) dut_w (
    .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .a(w_a), .b(w_b), .acc_clr(w_acc_clr), .out_valid(w_out_valid),
    .out_ready(always_ready), .result(w_result)
  );

  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;

  longint exp_q[$];
  longint lat_q[$];
  longint o_exp_q[$];
  longint w_exp_q[$];
  longint w_lat_q[$];

  longint model_acc = 0;
  longint o_model_acc = 0;
  longint w_model_acc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Random back-pressure. The value changes just after each rising edge, so
  // the negedge monitors see a stable value.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      out_ready = hold ? 1'b0 : ($urandom_range(0, 2) != 0);
    end
  end

  // Monitor for the default instance.
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && !prev_valid) begin
        if (lat_q.size() == 0) check("spurious_valid", 1, 0);
        else                   check("latency", cyc, lat_q.pop_front());
      end
      if (out_valid) check("in_ready_in_done", in_ready, 0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_result", 1, 0);
        else begin
          longint e;
          e = exp_q.pop_front();
          check("result", result, e);
          $display("main   result %0d expected %0d", result, e);
        end
      end
    end
    prev_valid <= out_valid;
  end

  // Monitor for the overflow instance (always ready: one negedge per result).
  always @(negedge clk) begin
    if (!rst && o_out_valid) begin
      if (o_exp_q.size() == 0) check("ovf_unexpected", 1, 0);
      else begin
        longint e;
        e = o_exp_q.pop_front();
        check("ovf_result", o_result, e);
        $display("ovf    result %0d expected %0d", o_result, e);
      end
    end
  end

  // Monitor for the wide instance.
  always @(negedge clk) begin
    if (!rst && w_out_valid) begin
      if (w_exp_q.size() == 0) check("wide_unexpected", 1, 0);
      else begin
        longint e;
        e = w_exp_q.pop_front();
        check("wide_result", w_result, e);
        check("wide_latency", cyc, w_lat_q.pop_front());
        $display("wide   result %0d expected %0d", w_result, e);
      end
    end
  end

  task automatic issue(input logic [7:0] ta, input logic [7:0] tv, input logic clr, input bit track);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      check("accept_timeout", in_ready, 1);
      return;
    end
    a = ta; b = tv; acc_clr = clr; in_valid = 1'b1;
    if (track) begin
      if (clr) model_acc = 0;
      model_acc = (model_acc + longint'(ta) * longint'(tv)) % (longint'(1) << 24);
      exp_q.push_back(model_acc);
      lat_q.push_back(cyc + 1 + 4);
    end
    @(negedge clk);
    // Garbage on the operand inputs after accept must not matter.
    in_valid = 1'b0; a = 8'($urandom); b = 8'($urandom); acc_clr = 1'($urandom);
  endtask

  task automatic o_issue(input logic [7:0] ta, input logic [7:0] tv, input logic clr);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!o_in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!o_in_ready) begin
      check("ovf_accept_timeout", o_in_ready, 1);
      return;
    end
    o_a = ta; o_b = tv; o_acc_clr = clr; o_in_valid = 1'b1;
    if (clr) o_model_acc = 0;
    o_model_acc = (o_model_acc + longint'(ta) * longint'(tv)) % 65536;
    o_exp_q.push_back(o_model_acc);
    @(negedge clk);
    o_in_valid = 1'b0;
  endtask

  task automatic w_issue(input logic [11:0] ta, input logic [11:0] tv, input logic clr);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!w_in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!w_in_ready) begin
      check("wide_accept_timeout", w_in_ready, 1);
      return;
    end
    w_a = ta; w_b = tv; w_acc_clr = clr; w_in_valid = 1'b1;
    if (clr) w_model_acc = 0;
    w_model_acc = (w_model_acc + longint'(ta) * longint'(tv)) % (longint'(1) << 24);
    w_exp_q.push_back(w_model_acc);
    w_lat_q.push_back(cyc + 1 + 9);
    @(negedge clk);
    w_in_valid = 1'b0;
  endtask

  // Wait (bounded) until every outstanding expectation has been consumed.
  task automatic drain();
    int guard;
    guard = 0;
    while ((exp_q.size() + lat_q.size() + o_exp_q.size() + w_exp_q.size()) != 0 && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    check("drain_pending", exp_q.size() + lat_q.size() + o_exp_q.size() + w_exp_q.size(), 0);
  endtask

  initial begin
    rst = 1'b1; hold = 1'b0; always_ready = 1'b1;
    in_valid = 1'b0; a = '0; b = '0; acc_clr = 1'b0;
    o_in_valid = 1'b0; o_a = '0; o_b = '0; o_acc_clr = 1'b0;
    w_in_valid = 1'b0; w_a = '0; w_b = '0; w_acc_clr = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset_in_ready", in_ready, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_result", result, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", in_ready, 1);

    // Directed cases: basic product, accumulate chain, extremes.
    issue(8'd200, 8'd150, 1'b1, 1'b1);
    issue(8'd3,   8'd5,   1'b1, 1'b1);
    issue(8'd7,   8'd11,  1'b0, 1'b1);
    issue(8'd0,   8'd99,  1'b0, 1'b1);
    issue(8'd255, 8'd255, 1'b1, 1'b1);
    issue(8'd0,   8'd255, 1'b1, 1'b1);

    // Randomized traffic with mixed acc_clr.
    for (int k = 0; k < 40; k++) begin
      issue(8'($urandom), 8'($urandom), ($urandom_range(0, 3) == 0), 1'b1);
    end
    drain();

    // Back-pressure: result holds and in_ready stays low while out_ready=0.
    hold = 1'b1;
    issue(8'd200, 8'd150, 1'b1, 1'b1);
    begin
      int guard;
      guard = 0;
      while (!out_valid && guard < 20) begin
        @(negedge clk);
        guard++;
      end
      check("bp_reach_done", out_valid, 1);
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("bp_result", result, 30000);
      check("bp_in_ready", in_ready, 0);
    end
    hold = 1'b0;
    drain();

    // Reset on the 2nd COMPUTE edge aborts the operation and clears acc.
    issue(8'd200, 8'd150, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_in_ready", in_ready, 0);
    check("abort_out_valid", out_valid, 0);
    check("abort_result", result, 0);
    rst = 1'b0;
    model_acc = 0;
    o_model_acc = 0;
    w_model_acc = 0;
    @(negedge clk);
    check("abort_release_in_ready", in_ready, 1);
    // acc_clr=0 onto the cleared accumulator gives the bare product.
    issue(8'd3, 8'd5, 1'b0, 1'b1);
    drain();

    // Accumulator wrap with ACC_WIDTH=16.
    o_issue(8'd255, 8'd255, 1'b1);
    o_issue(8'd255, 8'd255, 1'b0);
    for (int k = 0; k < 6; k++) begin
      o_issue(8'($urandom), 8'($urandom), ($urandom_range(0, 2) == 0));
    end
    drain();

    // 12-bit operands with three digits each (9-edge latency).
    w_issue(12'd4095, 12'd4095, 1'b1);
    for (int k = 0; k < 6; k++) begin
      w_issue(12'($urandom), 12'($urandom), ($urandom_range(0, 2) == 0));
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
